// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary datapath blocks.
// Holds decoder state, saturation limit and word width.
package unary_pkg;

  typedef enum logic {
    IDLE,
    COUNT
  } dec_state_t;

  localparam int unsigned DEF_BIN_BITS = 8;

  // Largest representable unary value for a given binary weight.
  function automatic int unsigned u_max(input int unsigned bin_bits);
    return 32'd1 << bin_bits;
  endfunction

  // Width of a decoded word (holds 0..2^bin_bits inclusive).
  function automatic int unsigned word_w(input int unsigned bin_bits);
    return bin_bits + 1;
  endfunction

endpackage

// File: rtl/unary_run_counter.sv
// Saturating run-length counter for unary streams.
// clr and inc together restart the count at one.
module unary_run_counter
  import unary_pkg::*;
#(
  parameter int unsigned BIN_BITS = DEF_BIN_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  output logic [BIN_BITS:0] count,
  output logic              sat_hit
);

  localparam int unsigned      W   = word_w(BIN_BITS);
  localparam logic [BIN_BITS:0] MAX = W'(u_max(BIN_BITS));
  localparam logic [BIN_BITS:0] ONE = W'(1);

  // Increment attempted while already pinned at the limit.
  assign sat_hit = inc && !clr && (count == MAX);

  // Count high cycles, saturating instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/unary_stream_decoder.sv
// Unary run-length stream to binary word decoder.
// Valid/ready output register with sticky overflow/drop flags.
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int unsigned BIN_BITS = DEF_BIN_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in,
  input  logic              in_zero,
  input  logic              clear,
  output logic [BIN_BITS:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow,
  output logic              dropped
);

  dec_state_t                     state;
  logic                           cnt_clr;
  logic                           cnt_inc;
  logic                           sat_hit;
  logic                           done;
  logic [BIN_BITS:0]              count;
  logic [word_w(BIN_BITS)-1:0]    done_val;

  unary_run_counter #(
    .BIN_BITS(BIN_BITS)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (count),
    .sat_hit(sat_hit)
  );

  // Counter control and word completion for this cycle.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    done     = 1'b0;
    done_val = '0;
    if (clear) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_clr = 1'b1;
          cnt_inc = in;
          done    = !in && in_zero;
        end
        COUNT: begin
          if (in) begin
            cnt_inc = 1'b1;
          end else begin
            cnt_clr  = 1'b1;
            done     = 1'b1;
            done_val = count;
          end
        end
      endcase
    end
  end

  assign busy = (state == COUNT);

  // FSM, sticky flags and the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      if (clear) begin
        state    <= IDLE;
        overflow <= 1'b0;
        dropped  <= 1'b0;
      end else begin
        unique case (state)
          IDLE:  if (in)  state <= COUNT;
          COUNT: if (!in) state <= IDLE;
        endcase
        if (sat_hit) overflow <= 1'b1;
      end
      if (done) begin
        if (!out_valid || out_ready) begin
          out_data  <= done_val;
          out_valid <= 1'b1;
        end else begin
          dropped <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Self-checking bench for unary_stream_decoder, BIN_BITS=4.
// Vector table plus directed handshake/clear/reset sequences.
module tb_unary_stream_decoder;

  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in;
  logic          in_zero;
  logic          clear;
  logic [BB:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overflow;
  logic          dropped;

  int total = 0;
  int bad   = 0;
  int bcnt;
  logic [BB:0] sb[$];

  unary_stream_decoder #(.BIN_BITS(BB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in),
    .in_zero  (in_zero),
    .clear    (clear),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overflow (overflow),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        ones;
    bit        zstrobe;
    bit        zhold;
    logic [BB:0] exp;
    bit        ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word must match the next expected value.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_spurious: got %0d expected none", out_data);
      end else begin
        logic [BB:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL sb_word: got %0d expected %0d", out_data, e);
        end
      end
    end
  end

  // n high cycles (optionally with in_zero held), then one low cycle.
  task automatic send_run(input int n, input bit zh, input bit push,
                          input logic [BB:0] e);
    bcnt = 0;
    for (int i = 0; i < n; i++) begin
      in = 1'b1;
      in_zero = zh;
      tick();
      if (busy) bcnt++;
    end
    in = 1'b0;
    in_zero = 1'b0;
    if (push) sb.push_back(e);
    tick();
  endtask

  task automatic send_zero(input bit push);
    in = 1'b0;
    in_zero = 1'b1;
    if (push) sb.push_back('0);
    tick();
    in_zero = 1'b0;
  endtask

  initial begin
    tbl[0] = '{5,  0, 0, 5'd5,  0};
    tbl[1] = '{0,  1, 0, 5'd0,  0};
    tbl[2] = '{3,  0, 1, 5'd3,  0};
    tbl[3] = '{1,  0, 0, 5'd1,  0};
    tbl[4] = '{16, 0, 0, 5'd16, 0};
    tbl[5] = '{20, 0, 0, 5'd16, 1};

    reset_n = 1'b0;
    in = 0; in_zero = 0; clear = 0; out_ready = 1;
    #12;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", dropped, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Table-driven back-to-back words, out_ready held high.
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].zstrobe) begin
        send_zero(1);
        bcnt = 0;
      end else begin
        send_run(tbl[k].ones, tbl[k].zhold, 1, tbl[k].exp);
      end
      chk($sformatf("tbl%0d_data", k), out_data, tbl[k].exp);
      chk($sformatf("tbl%0d_valid", k), out_valid, 1);
      chk($sformatf("tbl%0d_busy", k), bcnt, tbl[k].ones);
      chk($sformatf("tbl%0d_ovf", k), overflow, tbl[k].ovf);
    end
    tick();
    chk("idle_valid", out_valid, 0);
    clear = 1; tick(); clear = 0;
    chk("clr_ovf", overflow, 0);

    // Drop while stalled, then release.
    out_ready = 0;
    send_run(7, 0, 1, 5'd7);
    send_run(2, 0, 0, 5'd2);
    tick();
    chk("stall_data", out_data, 7);
    chk("stall_valid", out_valid, 1);
    chk("stall_drop", dropped, 1);
    out_ready = 1;
    tick();
    chk("accept_valid", out_valid, 0);
    send_run(9, 0, 1, 5'd9);
    chk("w9_data", out_data, 9);
    tick();

    // Accept and completion in the same cycle.
    clear = 1; tick(); clear = 0;
    out_ready = 0;
    send_run(4, 0, 1, 5'd4);
    for (int i = 0; i < 6; i++) begin
      in = 1; tick();
    end
    in = 0;
    out_ready = 1;
    sb.push_back(5'd6);
    tick();
    chk("same_data", out_data, 6);
    chk("same_valid", out_valid, 1);
    chk("same_drop", dropped, 0);
    tick();

    // Asynchronous reset mid-run.
    for (int i = 0; i < 3; i++) begin
      in = 1; tick();
    end
    #2 reset_n = 0;
    #1;
    chk("amid_busy", busy, 0);
    chk("amid_valid", out_valid, 0);
    in = 0;
    @(negedge clk);
    reset_n = 1;
    tick();
    chk("arst_idle_valid", out_valid, 0);
    send_run(2, 0, 1, 5'd2);
    chk("arst_data", out_data, 2);
    tick();

    // clear mid-run keeps the pending word.
    out_ready = 0;
    send_run(3, 0, 1, 5'd3);
    in = 1; tick();
    in = 1; tick();
    clear = 1; in = 1; tick();
    clear = 0; in = 0;
    tick(); tick();
    chk("clr_busy", busy, 0);
    chk("clr_valid", out_valid, 1);
    chk("clr_data", out_data, 3);
    out_ready = 1;
    tick(); tick();
    chk("clr_after_valid", out_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unary_stream_decoder.md
Name: unary_stream_decoder

Overview:
- Converts a serial unary (run-length) stream into a binary word with a valid/ready output handshake. It sits at the output end of the unary datapath, for example after the unary shift MAC/adder chain, so results can be checked or stored in binary.
- A value N arrives as N consecutive high cycles on `in`, terminated by a low cycle.
- A zero-valued word is signalled by a single-cycle `in_zero` strobe. This matches the multiplier's zero indication.

Parameters:
- BIN_BITS, default 8: binary weight of the stream. Legal values are 0..2^BIN_BITS inclusive. Output width is BIN_BITS+1.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- in  input  1  unary data stream; a high run encodes the value
- in_zero  input  1  single-cycle strobe marking a zero-valued word
- clear  input  1  synchronous clear: aborts the current run and clears sticky flags
- out_data  output  BIN_BITS+1  decoded value
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- busy  output  1  a run is in progress (state COUNT)
- overflow  output  1  sticky: a run exceeded 2^BIN_BITS
- dropped  output  1  sticky: a completed word was lost because the output register was occupied

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, overflow=0, dropped=0, state=IDLE, count=0.
- State IDLE:
  - in=1: count<=1, go to COUNT.
  - in=0 && in_zero=1: complete a word with value 0, stay in IDLE.
  - in=1 && in_zero=1: in_zero is ignored and the run starts.
- State COUNT:
  - in=1: count<=count+1, saturating at 2^BIN_BITS.
  - An increment attempted while count==2^BIN_BITS sets overflow.
  - in=0: complete a word with value count, count<=0, go to IDLE.
  - in_zero is ignored in COUNT.
- busy = (state==COUNT).
- Word completion and output register:
  - A completed word loads out_data and sets out_valid on the next clock edge, if out_valid==0 or out_ready==1 in the completion cycle.
  - Completion latency: out_valid is high on the cycle after the terminating low (or the in_zero strobe) is sampled.
  - If out_valid==1 && out_ready==0 at completion, the word is discarded, dropped is set, and out_data/out_valid are unchanged.
  - Handshake: out_valid && out_ready with no completion in the same cycle gives out_valid<=0. out_data holds its value.
  - Simultaneous accept and completion: the new word loads, out_valid stays 1, and nothing is dropped.
  - out_data must be stable while out_valid && !out_ready.
- Back-to-back words: the terminating low of word k is also the IDLE cycle. `in` going high on the next cycle starts word k+1, so the minimum spacing is one low cycle. A sustained one-word-per-(N+1)-cycles rate is lossless when out_ready is held high.
- clear:
  - Same cycle effect: state<=IDLE, count<=0, overflow<=0, dropped<=0.
  - Any in-flight run is discarded and produces no word.
  - out_valid/out_data are not affected, so a pending word stays deliverable.
  - clear has priority over in and in_zero in that cycle.
- Reset mid-run: everything returns to reset values immediately, asynchronously. The first word after reset_n deasserts starts at the first sampled in=1.
- Arithmetic: count is BIN_BITS+1 bits wide and unsigned. It never wraps; it saturates.

Decomposition:
- Package unary_pkg holds:
  - the decoder state enum {IDLE, COUNT};
  - the function u_max(BIN_BITS) = 1<<BIN_BITS;
  - the width constant for the decoded word.
  - The existing unary blocks can share this package.
- Sub-module unary_run_counter:
  - ports: clk, reset_n, clr, inc; outputs count (BIN_BITS+1) and sat_hit.
  - It implements the saturating increment and overflow detection.
- The FSM and the output register stay in the top module.

Test Plan:
- BIN_BITS=4, out_ready=1. in high for 5 cycles, then low → out_data=5 and out_valid=1 exactly one cycle after the low is sampled; busy=1 for 5 cycles.
- in_zero single pulse with in=0 → out_data=0, out_valid=1 next cycle. Then in=1&&in_zero=1 for 3 cycles, then low → out_data=3.
- BIN_BITS=4. in high for 16 cycles → out_data=16, overflow=0. in high for 20 cycles → out_data=16, overflow=1 (sticky). clear → overflow=0.
- out_ready=0. Send words 7 and 2 → out_data stays 7, dropped=1. Raise out_ready → word 7 is accepted and out_valid drops. Then send 9 with out_ready=1 → 9 is delivered.
- Accept and completion in the same cycle: pending word 4, out_ready=1 in the cycle word 6's terminator is sampled → next cycle out_data=6, out_valid=1, dropped=0.
- Assert reset_n low after 3 high cycles of a run, release, then send a run of 2 → out_data=2, with no stale count and no spurious word. Assert clear mid-run of 5 → no word emitted and pending out_valid is unchanged.
